uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Standalone UART receiver (8N1, LSB first) with oversampled start-bit qualification and mid-bit sampling.
- Consumer-side counterpart of the periodic byte transmitter in the UART test top.
- Presents received bytes through the rx_data / rx_ready / rx_ready_clear handshake.
- Flags framing errors and overruns for the loopback test top and future command parsers.

Parameters:
- CLK_HZ, 30000000, sys_clk frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE), sys_clk cycles per sample tick, integer-truncated; must be >= 1.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, asynchronous to sys_clk, idles high.
- rx_clk  out  1  one-cycle pulse per oversample tick, for observation.
- rx_data  out  8  last accepted byte.
- rx_ready  out  1  byte available; sticky until cleared.
- rx_ready_clear  in  1  consumer acknowledge, sampled each sys_clk.
- rx_frame_err  out  1  sticky: stop bit sampled low.
- rx_overrun  out  1  sticky: byte completed while rx_ready already set.

Behaviour:
- Reset (async) values:
  - rx_data=0, rx_ready=0, rx_frame_err=0, rx_overrun=0, rx_clk=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- rx passes through a 2-flop synchronizer; edge detection uses a third registered copy.
- Tick divider:
  - Counts 0..DIV-1 and pulses rx_clk at DIV-1.
  - Free-running; restarts at 0 on start-edge detection.
- FSM states: IDLE, START, DATA, STOP. Tick counter t runs 0..OVERSAMPLE-1 and bit counter b runs 0..7.
- IDLE: on synchronized falling edge (prev=1, cur=0), clear t and go to START.
- START: at tick t=OVERSAMPLE/2-1 (mid start bit):
  - rx=0: clear t and b, go to DATA.
  - rx=1: glitch, return to IDLE with no flags.
- DATA:
  - Every OVERSAMPLE ticks from start-bit centre, at t=OVERSAMPLE-1, shift rx into shift[7] (right shift, LSB first).
  - After b=7, go to STOP.
- STOP: sample at t=OVERSAMPLE-1 (mid stop bit), then return to IDLE. Edge detection re-arms from that cycle, so no half-bit dead time.
  - Stop=1, rx_ready=0: load rx_data, set rx_ready on the next sys_clk.
  - Stop=1, rx_ready=1, no clear this cycle: drop the byte, rx_data unchanged, set rx_overrun.
  - Stop=0: drop the byte, set rx_frame_err, rx_ready unchanged.
- Latency: rx_ready rises exactly 1 sys_clk after the mid-stop sample tick.
- rx_ready_clear:
  - Clears rx_ready, rx_frame_err and rx_overrun on the next edge.
  - Coincides with a valid completion: completion wins. rx_ready stays 1, rx_data takes the new byte, rx_overrun is not set (errors still clear).
- rx held low continuously (break):
  - Yields one frame_err.
  - No new start is detected until rx returns high and falls again.
- rst asserted mid-frame: abort immediately to the reset values; the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP. It samples an even-parity bit at t=OVERSAMPLE-1.
  - Adds output rx_parity_err (1 bit, sticky, cleared by rx_ready_clear, reset 0).
  - A mismatch sets rx_parity_err and still delivers the byte, with the normal ready/overrun rules.
- Undefined: 8N1 only; no PARITY state, no rx_parity_err port.

Decomposition:
- Package uart_defs holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - Default CLK_HZ/BAUD/OVERSAMPLE constants.
  - The DIV computation function; shared with the transmitter.
- Sub-module uart_baud_tick:
  - Parameterised divider producing the tick pulse, with a sync restart input.
  - Reusable by the transmitter (with OVERSAMPLE=1).

Test Plan (CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clocks):
- Drive frame 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> rx_ready rises 1 clk after mid-stop tick; rx_data=0x41, rx_frame_err=0.
- Low glitch of 40 clocks on idle line -> no rx_ready, FSM returns to IDLE; a following 0x55 frame is received correctly.
- Frame 0xA5 with stop bit driven 0 -> rx_frame_err=1, rx_ready=0, rx_data unchanged; rx_ready_clear pulse clears the flag.
- Two back-to-back frames 0x12, 0x34 without clear -> rx_data=0x12, rx_overrun=1. Repeat with clear pulsed on the cycle the second byte completes -> rx_data=0x34, rx_ready=1, rx_overrun=0.
- rst asserted at bit 4 of a frame, released, then frame 0x7E -> all outputs 0 during rst; 0x7E received cleanly.
- With UART_RX_PARITY_EN: frame 0x03 with parity bit 1 -> rx_data=0x03, rx_ready=1, rx_parity_err=1. With parity 0 -> rx_parity_err=0.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: shared UART state encodings, default line rates and divider helper
package uart_defs;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_e;

   localparam int unsigned DEF_CLK_HZ     = 30_000_000;
   localparam int unsigned DEF_BAUD       = 115_200;
   localparam int unsigned DEF_OVERSAMPLE = 16;

   // sys_clk cycles per sample tick, truncated
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                            input int unsigned os);
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks, with sync restart
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned W = DIV > 1 ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = cnt_q == W'(DIV - 1);
   assign cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + W'(1);

   // divider count register
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled 8N1 UART receiver with sticky ready/framing/overrun flags; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx_core
   import uart_defs::*;
#(
   parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready_clear,
   output logic       rx_clk,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       rx_parity_err,
`endif
   output logic       rx_overrun
);

   localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned TW  = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
   localparam uart_state_e AFTER_DATA = PARITY;
`else
   localparam uart_state_e AFTER_DATA = STOP;
`endif

   logic        sync1_q, sync2_q, prev_q;
   uart_state_e state_q, state_d;
   logic [TW-1:0] t_q, t_d;
   logic [2:0]  b_q, b_d;
   logic [7:0]  shift_q, shift_d, data_q, data_d;
   logic        ready_q, ready_d, fe_q, fe_d, ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
   logic        perr_q, perr_d;
   assign rx_parity_err = perr_q;
`endif
   logic        fall, tick;

   assign fall         = prev_q & ~sync2_q;
   assign rx_clk       = tick;
   assign rx_data      = data_q;
   assign rx_ready     = ready_q;
   assign rx_frame_err = fe_q;
   assign rx_overrun   = ov_q;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_i    (sys_clk),
      .rst_i    (rst),
      .restart_i(state_q == IDLE && fall),
      .tick_o   (tick)
   );

   // frame sequencing; a completion in the same cycle as a clear takes priority over the clear
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      b_d     = b_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = ready_q & ~rx_ready_clear;
      fe_d    = fe_q & ~rx_ready_clear;
      ov_d    = ov_q & ~rx_ready_clear;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q & ~rx_ready_clear;
`endif
      case (state_q)
         IDLE: if (fall) begin
            t_d     = '0;
            state_d = START;
         end
         START: if (tick) begin
            t_d = t_q + TW'(1);
            if (t_q == T_MID) begin
               t_d     = '0;
               b_d     = '0;
               state_d = sync2_q ? IDLE : DATA;
            end
         end
         DATA: if (tick) begin
            t_d = t_q + TW'(1);
            if (t_q == T_LAST) begin
               t_d     = '0;
               b_d     = b_q + 3'd1;
               shift_d = {sync2_q, shift_q[7:1]};
               state_d = b_q == 3'd7 ? AFTER_DATA : DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            t_d = t_q + TW'(1);
            if (t_q == T_LAST) begin
               t_d     = '0;
               perr_d  = perr_d | ^{shift_q, sync2_q};
               state_d = STOP;
            end
         end
`endif
         STOP: if (tick) begin
            t_d = t_q + TW'(1);
            if (t_q == T_LAST) begin
               t_d     = '0;
               state_d = IDLE;
               if (!sync2_q) fe_d = 1'b1;
               else if (!ready_q || rx_ready_clear) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
               end else ov_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // synchronizer, edge history and receiver state registers
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         t_q     <= '0;
         b_q     <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         t_q     <= t_d;
         b_q     <= b_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven, hand-sequenced and randomized checks of uart_rx_core
module tb_uart_rx_core;

   localparam int unsigned BIT = 160;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 1523 + 160;
`else
   localparam int LAT = 1523;
`endif

   logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready_clear = 1'b0;
   logic       rx_clk, rx_ready, rx_frame_err, rx_overrun;
   logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
`endif

   int tests = 0, fails = 0;
   int cyc = 0, start_cyc = 0;
   logic lat_chk = 1'b0, ready_prev = 1'b0, clk_prev = 1'b0;
   logic       m_r = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
   logic [7:0] m_d = 8'h00;

   typedef struct {
      logic       clr;
      logic [7:0] d;
      logic       stop;
      logic       e_r;
      logic [7:0] e_d;
      logic       e_fe;
      logic       e_ov;
   } vec_t;
   vec_t tbl[6];

   uart_rx_core #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
      .sys_clk       (clk),
      .rst           (rst),
      .rx            (rx),
      .rx_ready_clear(rx_ready_clear),
      .rx_clk        (rx_clk),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
`ifdef UART_RX_PARITY_EN
      .rx_parity_err (rx_parity_err),
`endif
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic r, input logic [7:0] d, input logic fe,
                            input logic ov);
      check({tag, " ready"}, 32'(rx_ready), 32'(r));
      check({tag, " data"}, 32'(rx_data), 32'(d));
      check({tag, " frame_err"}, 32'(rx_frame_err), 32'(fe));
      check({tag, " overrun"}, 32'(rx_overrun), 32'(ov));
   endtask

   // every rising edge of rx_ready must follow an observed tick by one clock
   always @(negedge clk) begin
      if (rx_ready && !ready_prev && !rst) begin
         check("ready after tick", 32'(clk_prev), 32'd1);
         if (lat_chk) check("ready latency", 32'(cyc - start_cyc), 32'(LAT));
      end
      ready_prev = rx_ready;
      clk_prev   = rx_clk;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_cyc(BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop);
      rx = 1'b1;
   endtask

   task automatic pulse_clear();
      rx_ready_clear = 1'b1;
      wait_cyc(1);
      rx_ready_clear = 1'b0;
      m_r  = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (!stop) m_fe = 1'b1;
      else if (!m_r) begin
         m_r = 1'b1;
         m_d = d;
      end else m_ov = 1'b1;
   endtask

   initial begin
      tbl[0] = '{1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 8'h34, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};

      wait_cyc(3);
      check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
      check("reset rx_clk", 32'(rx_clk), 32'd0);
      rst = 1'b0;
      wait_cyc(50);

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].clr) pulse_clear();
         lat_chk = i == 0;
         send_frame(tbl[i].d, tbl[i].stop);
         lat_chk = 1'b0;
         wait_cyc(5);
         check_all($sformatf("vec%0d", i), tbl[i].e_r, tbl[i].e_d, tbl[i].e_fe, tbl[i].e_ov);
      end
      m_r  = tbl[5].e_r;
      m_d  = tbl[5].e_d;
      m_fe = tbl[5].e_fe;
      m_ov = tbl[5].e_ov;

      pulse_clear();
      check_all("clear", 1'b0, 8'h55, 1'b0, 1'b0);

      rx = 1'b0;
      wait_cyc(40);
      rx = 1'b1;
      wait_cyc(300);
      check_all("glitch", 1'b0, 8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b1);
      wait_cyc(5);
      check_all("post-glitch", 1'b1, 8'h55, 1'b0, 1'b0);

      pulse_clear();
      send_frame(8'h12, 1'b1);
      send_frame(8'h56, 1'b1);
      wait_cyc(5);
      check_all("overrun", 1'b1, 8'h12, 1'b0, 1'b1);
      fork
         send_frame(8'h34, 1'b1);
         begin
            wait_cyc(LAT - 8);
            for (int i = 0; i < 20 && rx_clk !== 1'b1; i++) wait_cyc(1);
            rx_ready_clear = 1'b1;
            wait_cyc(1);
            rx_ready_clear = 1'b0;
         end
      join
      wait_cyc(5);
      check_all("clear+complete", 1'b1, 8'h34, 1'b0, 1'b0);

      pulse_clear();
      rx = 1'b0;
      wait_cyc(2000);
      check_all("break", 1'b0, 8'h34, 1'b1, 1'b0);
      rx = 1'b1;
      wait_cyc(20);
      send_frame(8'h3C, 1'b1);
      wait_cyc(5);
      check_all("post-break", 1'b1, 8'h3C, 1'b1, 1'b0);

      fork
         send_frame(8'h99, 1'b1);
         begin
            wait_cyc(5 * BIT);
            rst = 1'b1;
            #1;
            check_all("mid-frame rst", 1'b0, 8'h00, 1'b0, 1'b0);
            check("rst rx_clk", 32'(rx_clk), 32'd0);
            wait_cyc(3);
            check_all("held rst", 1'b0, 8'h00, 1'b0, 1'b0);
         end
      join_any
      disable fork;
      rx = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(200);
      send_frame(8'h7E, 1'b1);
      wait_cyc(5);
      check_all("post-rst", 1'b1, 8'h7E, 1'b0, 1'b0);
      m_r  = 1'b1;
      m_d  = 8'h7E;
      m_fe = 1'b0;
      m_ov = 1'b0;

      for (int i = 0; i < 16; i++) begin
         logic [7:0] d;
         logic stop;
         d    = 8'($urandom);
         stop = $urandom_range(0, 4) != 0;
         if ($urandom_range(0, 2) == 0) pulse_clear();
         send_frame(d, stop);
         model_frame(d, stop);
         wait_cyc(5);
         check_all($sformatf("rand%0d", i), m_r, m_d, m_fe, m_ov);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
